xgmii_xconnect: RTL and testbench

- Parametrised N-port XGMII crossconnect for the l2switch top.
- Each TX port forwards the 72-bit XGMII stream of one runtime-selectable RX port.
- Source changes and link-down events are handled only at frame boundaries, so no truncated or spliced frames reach the wire.
- Replaces fixed pairwise port wiring; sits between the xgmii2fifo72 RX outputs and the PHY TX inputs, all on sys_clk.

---
 rtl/xgmii_xconnect.sv | 163 ++++++++++++++++
 tb/tb_xgmii_xconnect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xgmii_xconnect.sv
// N-port XGMII crossconnect: each TX port forwards one runtime-selected RX port, switching only at frame
// boundaries. Define XCONNECT_STATS_EN to build the per-TX frame/abort counters.
module xgmii_xconnect #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned SELW  = 3,
    parameter int unsigned CNTW  = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NPORT*72-1:0]   xgmii_rx,
    input  logic [NPORT-1:0]      port_en,
    input  logic [NPORT*SELW-1:0] cfg_map,
    output logic [NPORT*72-1:0]   xgmii_tx,
    output logic [NPORT*CNTW-1:0] tx_frames,
    output logic [NPORT*CNTW-1:0] tx_aborts
);
    localparam logic [71:0] IDLE_WORD = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR_WORD  = {8'hFF, 64'h07070707070707FE};

    typedef enum logic {ST_WAIT, ST_PASS} state_t;

    function automatic logic f_has_start(input logic [71:0] w);
        return (w[64] && (w[7:0] == 8'hFB)) || (w[68] && (w[39:32] == 8'hFB));
    endfunction

    logic [71:0]      w_rx [NPORT];
    logic [NPORT-1:0] w_rx_idle;
    logic [NPORT-1:0] w_rx_start;
    logic [NPORT-1:0] w_in_frame_nxt;
    logic [NPORT-1:0] r_in_frame;

    // RX frame tracker: the last START/TERM lane in a word decides the in-frame state after it
    always_comb begin
        for (int i = 0; i < int'(NPORT); i++) begin
            w_rx[i]           = xgmii_rx[i*72 +: 72];
            w_rx_idle[i]      = (w_rx[i] == IDLE_WORD);
            w_rx_start[i]     = f_has_start(w_rx[i]);
            w_in_frame_nxt[i] = r_in_frame[i];
            for (int k = 0; k < 8; k++) begin
                if (w_rx[i][64+k] && (w_rx[i][8*k +: 8] == 8'hFB) && ((k == 0) || (k == 4)))
                    w_in_frame_nxt[i] = 1'b1;
                if (w_rx[i][64+k] && (w_rx[i][8*k +: 8] == 8'hFD))
                    w_in_frame_nxt[i] = 1'b0;
            end
        end
    end

    state_t          r_state [NPORT];
    state_t          w_state_nxt [NPORT];
    logic [SELW-1:0] r_sel [NPORT];
    logic [SELW-1:0] w_sel_nxt [NPORT];
    logic [71:0]     r_tx [NPORT];
    logic [71:0]     w_tx_nxt [NPORT];
    logic [SELW-1:0] w_cfg [NPORT];
    logic [71:0]     w_src_word [NPORT];
    logic [NPORT-1:0] w_cfg_ok;
    logic [NPORT-1:0] w_cfg_idle;
    logic [NPORT-1:0] w_src_en;
    logic [NPORT-1:0] w_src_idle;
    logic [NPORT-1:0] w_src_start;
    logic [NPORT-1:0] w_src_inf;

    // Per-TX next-state/output; out-of-range selects never match a port and so never leave WAIT
    always_comb begin
        for (int t = 0; t < int'(NPORT); t++) begin
            w_cfg[t]       = cfg_map[t*SELW +: SELW];
            w_state_nxt[t] = r_state[t];
            w_sel_nxt[t]   = r_sel[t];
            w_tx_nxt[t]    = IDLE_WORD;
            w_cfg_ok[t]    = 1'b0;
            w_cfg_idle[t]  = 1'b0;
            w_src_word[t]  = IDLE_WORD;
            w_src_en[t]    = 1'b0;
            w_src_idle[t]  = 1'b0;
            w_src_start[t] = 1'b0;
            w_src_inf[t]   = 1'b0;
            for (int j = 0; j < int'(NPORT); j++) begin
                if (w_cfg[t] == SELW'(j)) begin
                    w_cfg_ok[t]   = port_en[j];
                    w_cfg_idle[t] = w_rx_idle[j];
                end
                if (r_sel[t] == SELW'(j)) begin
                    w_src_word[t]  = w_rx[j];
                    w_src_en[t]    = port_en[j];
                    w_src_idle[t]  = w_rx_idle[j];
                    w_src_start[t] = w_rx_start[j];
                    w_src_inf[t]   = r_in_frame[j];
                end
            end
            if (r_state[t] == ST_WAIT) begin
                w_sel_nxt[t] = w_cfg[t];
                if (w_cfg_ok[t] && w_cfg_idle[t])
                    w_state_nxt[t] = ST_PASS;
            end else begin
                if (!w_src_en[t]) begin
                    w_state_nxt[t] = ST_WAIT;
                    if (w_src_inf[t] || w_src_start[t])
                        w_tx_nxt[t] = ERR_WORD;
                end else if ((w_cfg[t] != r_sel[t]) && w_src_idle[t]) begin
                    w_state_nxt[t] = ST_WAIT;
                end else begin
                    w_tx_nxt[t] = w_src_word[t];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_in_frame <= '0;
            for (int t = 0; t < int'(NPORT); t++) begin
                r_state[t] <= ST_WAIT;
                r_sel[t]   <= '0;
                r_tx[t]    <= IDLE_WORD;
            end
        end else begin
            r_in_frame <= w_in_frame_nxt;
            for (int t = 0; t < int'(NPORT); t++) begin
                r_state[t] <= w_state_nxt[t];
                r_sel[t]   <= w_sel_nxt[t];
                r_tx[t]    <= w_tx_nxt[t];
            end
        end
    end

    always_comb begin
        for (int t = 0; t < int'(NPORT); t++)
            xgmii_tx[t*72 +: 72] = r_tx[t];
    end

`ifdef XCONNECT_STATS_EN
    logic [CNTW-1:0] r_frames [NPORT];
    logic [CNTW-1:0] r_aborts [NPORT];

    // Counters follow the registered output word, so they advance on the same edge it appears
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int t = 0; t < int'(NPORT); t++) begin
                r_frames[t] <= '0;
                r_aborts[t] <= '0;
            end
        end else begin
            for (int t = 0; t < int'(NPORT); t++) begin
                if (f_has_start(w_tx_nxt[t]))
                    r_frames[t] <= r_frames[t] + CNTW'(1);
                if ((r_state[t] == ST_PASS) && !w_src_en[t] && (w_src_inf[t] || w_src_start[t]))
                    r_aborts[t] <= r_aborts[t] + CNTW'(1);
            end
        end
    end

    always_comb begin
        for (int t = 0; t < int'(NPORT); t++) begin
            tx_frames[t*CNTW +: CNTW] = r_frames[t];
            tx_aborts[t*CNTW +: CNTW] = r_aborts[t];
        end
    end
`else
    assign tx_frames = '0;
    assign tx_aborts = '0;
`endif

endmodule

// File: tb/tb_xgmii_xconnect.sv
// Directed bench for xgmii_xconnect (NPORT=4): forwarding latency, frame-boundary switching,
// link-drop abort, multicast, out-of-range select and async reset.
module tb_xgmii_xconnect;
    localparam logic [71:0] IDLE = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR  = {8'hFF, 64'h07070707070707FE};
    localparam logic [71:0] SOF0 = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] SOF4 = {8'h1F, 64'h555555FB07070707};
    localparam logic [71:0] EOF  = {8'hFF, 64'h07070707070707FD};

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [287:0] xgmii_rx;
    logic [3:0]   port_en;
    logic [11:0]  cfg_map;
    logic [287:0] xgmii_tx;
    logic [127:0] tx_frames;
    logic [127:0] tx_aborts;

    logic [71:0] rx [4];
    logic [2:0]  cfg [4];
    logic [71:0] tx [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xgmii_rx[i*72 +: 72] = rx[i];
            cfg_map[i*3 +: 3]    = cfg[i];
            tx[i]                = xgmii_tx[i*72 +: 72];
        end
    end

    xgmii_xconnect u_dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .xgmii_rx (xgmii_rx),
        .port_en  (port_en),
        .cfg_map  (cfg_map),
        .xgmii_tx (xgmii_tx),
        .tx_frames(tx_frames),
        .tx_aborts(tx_aborts)
    );

    function automatic logic [71:0] dw(input logic [63:0] d);
        return {8'h00, d};
    endfunction

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic all_idle();
        for (int i = 0; i < 4; i++) rx[i] = IDLE;
    endtask

    logic [71:0] s0 [15];
    logic [71:0] s1 [15];
    logic [71:0] s2 [15];
    logic [71:0] e1 [15];

    initial begin
        all_idle();
        port_en = 4'hF;
        cfg[0] = 3'd1; cfg[1] = 3'd0; cfg[2] = 3'd3; cfg[3] = 3'd2;

        // reset state
        tick(); tick();
        for (int i = 0; i < 4; i++) chk($sformatf("reset tx%0d", i), tx[i], IDLE);
        sys_rst = 1'b0;
        tick(); tick(); tick();

        // swapped pairs: rx0 -> tx1, rx1 -> tx0, one cycle latency
        s0[0] = SOF0; s1[0] = SOF0;
        for (int k = 1; k <= 8; k++) begin
            s0[k] = dw(64'(k) * 64'h0101010101010101);
            s1[k] = dw(64'hA5A5_0000_0000_0000 | 64'(k));
        end
        s0[9] = EOF; s1[9] = EOF;
        for (int c = 0; c < 10; c++) begin
            rx[0] = s0[c]; rx[1] = s1[c];
            tick();
            chk($sformatf("pair tx1 c%0d", c), tx[1], s0[c]);
            chk($sformatf("pair tx0 c%0d", c), tx[0], s1[c]);
        end
        all_idle();
        tick();
        chk("pair tx1 idle", tx[1], IDLE);

        // tx1 re-selected 0 -> 2 during rx0 word 2: finish rx0 frame, wait for rx2 idle
        for (int c = 0; c < 15; c++) begin s0[c] = IDLE; s2[c] = IDLE; end
        s0[0] = SOF0;
        for (int c = 1; c <= 4; c++) s0[c] = dw(64'h1111_0000_0000_0000 | 64'(c));
        s0[5] = EOF;
        s2[4] = SOF0;
        for (int c = 5; c <= 8; c++) s2[c] = dw(64'h2222_0000_0000_0000 | 64'(c));
        s2[9] = EOF; s2[11] = SOF0; s2[12] = dw(64'h2222_FFFF_0000_0001); s2[13] = EOF;
        for (int c = 0; c < 15; c++) e1[c] = (c <= 5) ? s0[c] : ((c <= 10) ? IDLE : s2[c]);
        for (int c = 0; c < 15; c++) begin
            rx[0] = s0[c]; rx[2] = s2[c];
            if (c == 2) cfg[1] = 3'd2;
            tick();
            chk($sformatf("resel tx1 c%0d", c), tx[1], e1[c]);
            chk($sformatf("resel tx3 c%0d", c), tx[3], s2[c]);
        end
        cfg[1] = 3'd0;
        tick(); tick(); tick();

        // link drop on rx0 mid-frame: exactly one ERR then IDLE
        rx[0] = SOF0; tick(); chk("drop tx1 sof", tx[1], SOF0);
        rx[0] = dw(64'h3333_0000_0000_0001); tick(); chk("drop tx1 d1", tx[1], rx[0]);
        rx[0] = dw(64'h3333_0000_0000_0002); tick(); chk("drop tx1 d2", tx[1], rx[0]);
        rx[0] = dw(64'h3333_0000_0000_0003); port_en = 4'b1110;
        tick(); chk("drop tx1 err", tx[1], ERR);
        rx[0] = dw(64'h3333_0000_0000_0004); tick(); chk("drop tx1 idle1", tx[1], IDLE);
        rx[0] = EOF; tick(); chk("drop tx1 idle2", tx[1], IDLE);
        rx[0] = IDLE; port_en = 4'hF;
        tick(); tick(); tick();
        // link drop outside a frame: no ERR
        port_en = 4'b1110; tick(); chk("idle drop tx1", tx[1], IDLE);
        tick(); chk("idle drop tx1 hold", tx[1], IDLE);
        port_en = 4'hF; tick(); tick();
`ifdef XCONNECT_STATS_EN
        chk("aborts tx1", 72'(tx_aborts[32 +: 32]), 72'(1));
`endif

        // multicast rx2 -> tx2 and tx3, START in lane 4
        cfg[2] = 3'd2;
        tick(); tick(); tick();
        s2[0] = SOF4; s2[1] = dw(64'h4444_5555_6666_7777); s2[2] = dw(64'h8888_9999_AAAA_BBBB);
        s2[3] = EOF; s2[4] = IDLE;
        for (int c = 0; c < 5; c++) begin
            rx[2] = s2[c];
            tick();
            chk($sformatf("mcast tx2 c%0d", c), tx[2], s2[c]);
            chk($sformatf("mcast tx3 c%0d", c), tx[3], s2[c]);
        end
`ifdef XCONNECT_STATS_EN
        chk("frames tx2", 72'(tx_frames[64 +: 32]), 72'(1));
        chk("frames tx3", 72'(tx_frames[96 +: 32]), 72'(3));
`endif

        // out-of-range select holds tx0 at IDLE under traffic on every port
        cfg[0] = 3'd7;
        tick(); tick();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++)
                rx[i] = (c == 0) ? SOF0 : (c == 6) ? EOF : (c == 7) ? IDLE : dw({$urandom, $urandom});
            tick();
            chk($sformatf("oor tx0 c%0d", c), tx[0], IDLE);
        end

        // async reset mid-frame on rx1 -> tx0
        cfg[0] = 3'd1;
        tick(); tick(); tick();
        rx[1] = SOF0; tick(); chk("rst tx0 sof", tx[0], SOF0);
        rx[1] = dw(64'h5555_0000_0000_0001); tick(); chk("rst tx0 d1", tx[0], rx[1]);
        rx[1] = dw(64'h5555_0000_0000_0002); tick(); chk("rst tx0 d2", tx[0], rx[1]);
        #2 sys_rst = 1'b1;
        #1 chk("rst tx0 async", tx[0], IDLE);
        rx[1] = dw(64'h5555_0000_0000_0003); tick(); chk("rst tx0 held1", tx[0], IDLE);
        rx[1] = dw(64'h5555_0000_0000_0004); tick(); chk("rst tx0 held2", tx[0], IDLE);
        sys_rst = 1'b0;
        rx[1] = dw(64'h5555_0000_0000_0005); tick(); chk("rst tx0 wait d5", tx[0], IDLE);
        rx[1] = EOF; tick(); chk("rst tx0 wait eof", tx[0], IDLE);
        rx[1] = IDLE; tick(); chk("rst tx0 wait idle", tx[0], IDLE);
        rx[1] = SOF0; tick(); chk("rst tx0 resume sof", tx[0], SOF0);
        rx[1] = dw(64'h6666_0000_0000_0001); tick(); chk("rst tx0 resume d1", tx[0], rx[1]);
        rx[1] = EOF; tick(); chk("rst tx0 resume eof", tx[0], EOF);
        rx[1] = IDLE; tick();

`ifndef XCONNECT_STATS_EN
        chk("frames tied", 72'(|tx_frames), 72'(0));
        chk("aborts tied", 72'(|tx_aborts), 72'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
